spi_reg_master: RTL and testbench

SPI initiator that issues single register read/write frames to the TinyQV peripheral-harness SPI register slave (`spi_reg`, `ADDR_W=4`). It serializes a command from a valid/ready request port onto mode-0 SPI and returns captured read data on a one-cycle response strobe. It sits in test/bring-up logic as the driver for the harness's register access path: `uio` bits for CS, SCK and MOSI, and the slave's MISO.

---
 rtl/spi_reg_pkg.sv | 32 +++
 rtl/synchronizer.sv | 37 +++
 rtl/spi_reg_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_spi_reg_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// ----------------------------------------------------------------------------
// spi_reg_pkg
//   Shared definitions for the SPI register-access master:
//   - frame geometry (16-bit frame: 1 direction bit, 7-bit address, 8-bit data)
//   - the master's state enumeration
//   - build_frame(): assembles the outgoing frame for a command
// ----------------------------------------------------------------------------
package spi_reg_pkg;

  localparam int FRAME_BITS   = 16;
  localparam int ADDR_FIELD_W = 7;
  localparam int DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    DONE
  } state_t;

  // Reads carry an all-zero data field on MOSI.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                    wr,
    input logic [ADDR_FIELD_W-1:0] addr,
    input logic [DATA_W-1:0]       data
  );
    return {wr, addr, (wr ? data : {DATA_W{1'b0}})};
  endfunction

endpackage

// File: rtl/synchronizer.sv
// ----------------------------------------------------------------------------
// synchronizer
//   Multi-flop synchronizer for bringing asynchronous signals into clk.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset (all stages clear to 0)
//     d     - asynchronous input
//     q     - synchronized output (STAGES cycles of delay)
// ----------------------------------------------------------------------------
module synchronizer #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/spi_reg_master.sv
// ----------------------------------------------------------------------------
// spi_reg_master
//   SPI mode-0 initiator issuing single 16-bit register read/write frames
//   ({write, 7-bit addr, 8-bit data}, MSB first) to an spi_reg slave.
//
//   Build option: define SPI_MASTER_MISO_SYNC_EN to pass spi_miso through a
//   2-stage synchronizer before sampling (needs CLK_DIV >= 6).
//
//   Parameters:
//     ADDR_W  - register address width (1..7), zero-extended into the frame
//     CLK_DIV - clk cycles per SCK half-period (D)
//   Ports:
//     clk, rst_n            - clock, asynchronous active-low reset
//     cmd_valid/cmd_ready   - request handshake (ready only in IDLE)
//     cmd_write             - 1 = write, 0 = read
//     cmd_addr, cmd_wdata   - register address and write data
//     rsp_valid             - one-cycle pulse when the frame completes
//     rsp_rdata             - read data (0x00 after writes), held
//     busy                  - high from the cycle after accept through rsp_valid
//     spi_cs_n, spi_clk,
//     spi_mosi, spi_miso    - SPI bus (all outputs registered)
// ----------------------------------------------------------------------------
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter guards
  // --------------------------------------------------------------------------
  generate
    if (ADDR_W < 1 || ADDR_W > ADDR_FIELD_W) begin : g_bad_addr_w
      $error("spi_reg_master: ADDR_W must be in 1..7");
    end
`ifdef SPI_MASTER_MISO_SYNC_EN
    if (CLK_DIV < 6) begin : g_bad_div_sync
      $error("spi_reg_master: CLK_DIV must be >= 6 with the MISO synchronizer");
    end
`else
    if (CLK_DIV < 4) begin : g_bad_div
      $error("spi_reg_master: CLK_DIV must be >= 4");
    end
`endif
  endgenerate

  // --------------------------------------------------------------------------
  // MISO input path
  // --------------------------------------------------------------------------
  logic miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
  synchronizer #(
    .STAGES(2),
    .WIDTH (1)
  ) u_miso_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (spi_miso),
    .q    (miso_s)
  );
`else
  assign miso_s = spi_miso;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                  state_reg,     state_next;
  logic [DIV_W-1:0]        div_reg,       div_next;
  logic [3:0]              bit_reg,       bit_next;
  logic [FRAME_BITS-1:0]   shift_reg,     shift_next;
  logic [DATA_W-1:0]       rx_reg,        rx_next;
  logic                    write_reg,     write_next;
  logic                    cs_n_reg,      cs_n_next;
  logic                    sclk_reg,      sclk_next;
  logic                    mosi_reg,      mosi_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]       rsp_rdata_reg, rsp_rdata_next;

  logic [ADDR_FIELD_W-1:0] addr_ext;
  assign addr_ext = ADDR_FIELD_W'(cmd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      rx_reg        <= '0;
      write_reg     <= 1'b0;
      cs_n_reg      <= 1'b1;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      div_reg       <= div_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      rx_reg        <= rx_next;
      write_reg     <= write_next;
      cs_n_reg      <= cs_n_next;
      sclk_reg      <= sclk_next;
      mosi_reg      <= mosi_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / registered-output logic. Every SPI output is computed here
  // as a _next value so the pins come straight from flops.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    div_next       = div_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    rx_next        = rx_reg;
    write_next     = write_reg;
    cs_n_next      = cs_n_reg;
    sclk_next      = sclk_reg;
    mosi_next      = mosi_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;

    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          shift_next = build_frame(cmd_write, addr_ext, cmd_wdata);
          write_next = cmd_write;
          mosi_next  = cmd_write;  // frame bit 15
          cs_n_next  = 1'b0;
          sclk_next  = 1'b0;
          div_next   = '0;
          bit_next   = '0;
          state_next = SETUP;
        end
      end

      SETUP: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          state_next = SHIFT;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      SHIFT: begin
        if (!sclk_reg) begin
          // Low phase. The first bit was already presented in SETUP; for the
          // others, MOSI moves on the cycle after the falling edge, which
          // leaves the slave a full cycle of hold after it sampled.
          if (div_reg == '0 && bit_reg != '0) begin
            shift_next = {shift_reg[FRAME_BITS-2:0], shift_reg[FRAME_BITS-1]};
            mosi_next  = shift_reg[FRAME_BITS-2];
          end
          if (div_reg == DIV_LAST) begin
            div_next  = '0;
            sclk_next = 1'b1;
          end else begin
            div_next = div_reg + 1'b1;
          end
        end else begin
          // High phase: sample on the last cycle, then fall.
          if (div_reg == DIV_LAST) begin
            rx_next   = {rx_reg[DATA_W-2:0], miso_s};
            div_next  = '0;
            sclk_next = 1'b0;
            bit_next  = bit_reg + 1'b1;  // wraps 15->0 exactly on SHIFT exit
            if (bit_reg == BIT_LAST) begin
              state_next = HOLD;
            end
          end else begin
            div_next = div_reg + 1'b1;
          end
        end
      end

      HOLD: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          cs_n_next  = 1'b1;
          mosi_next  = 1'b0;  // park MOSI low with the bus deselected
          state_next = GAP;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      GAP: begin
        if (div_reg == DIV_LAST) begin
          div_next       = '0;
          rsp_valid_next = 1'b1;
          // Only the last 8 samples (bits 7..0) survive in rx_reg.
          rsp_rdata_next = write_reg ? '0 : rx_reg;
          state_next     = DONE;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign spi_cs_n  = cs_n_reg;
  assign spi_clk   = sclk_reg;
  assign spi_mosi  = mosi_reg;

endmodule

// File: tb/tb_spi_reg_master.sv
// ----------------------------------------------------------------------------
// tb_spi_reg_master
//   Self-checking bench for spi_reg_master with a behavioural spi_reg slave.
//   Expected frames, read data and latencies are computed from the frame
//   format and timing rules; the slave keeps its own register file, so
//   corrupted write frames surface on later reads.
// ----------------------------------------------------------------------------
module tb_spi_reg_master;

`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int D = 6;
`else
  localparam int D = 4;
`endif
  localparam int LAT = 35 * D + 1;
  localparam int A2A = 35 * D + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;

  int checks = 0;
  int errors = 0;

  spi_reg_master #(
    .ADDR_W (4),
    .CLK_DIV(D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Cycle counter and handshake monitors (edge index of accept / response)
  // --------------------------------------------------------------------------
  int cyc = 0;
  int acc_q[$];
  int rsp_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (rsp_valid) rsp_q.push_back(cyc);
  end

  // --------------------------------------------------------------------------
  // Behavioural spi_reg slave: MOSI captured on SCK rise, MISO driven after
  // SCK fall; the register read is returned during the second byte.
  // --------------------------------------------------------------------------
  logic [7:0]  s_mem [16];
  logic [15:0] s_sh = '0;
  logic [3:0]  s_addr = '0;
  logic        s_prev = 1'b0;
  logic        miso_drv = 1'b0;
  int          s_cnt = 0;
  logic [15:0] frame_q[$];

  assign spi_miso = miso_drv;

  always @(negedge clk) begin
    if (spi_cs_n !== 1'b0) begin
      s_cnt    = 0;
      miso_drv = 1'b0;
    end else begin
      if (spi_clk && !s_prev) begin
        s_sh  = {s_sh[14:0], spi_mosi};
        s_cnt = s_cnt + 1;
        if (s_cnt == 8) s_addr = s_sh[3:0];
        if (s_cnt == 16) begin
          frame_q.push_back(s_sh);
          if (s_sh[15]) s_mem[s_sh[11:8]] = s_sh[7:0];
        end
      end
      if (!spi_clk && s_prev && s_cnt >= 8 && s_cnt < 16) begin
        miso_drv = s_mem[s_addr][15 - s_cnt];
      end
    end
    s_prev = spi_clk;
  end

  // Reference register contents as the requester expects them to be.
  logic [7:0] ref_mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated command: issue, wait for the response, check everything.
  task automatic run_cmd(input logic w, input logic [3:0] a, input logic [7:0] d, input string tag);
    int n;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rd;
    exp_frame = {w, 3'b000, a, (w ? d : 8'h00)};
    exp_rd    = w ? 8'h00 : ref_mem[a];
    acc_q.delete(); rsp_q.delete(); frame_q.delete();
    @(negedge clk);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_q.size() == 0 && n < 4 * LAT) begin @(negedge clk); n++; end
    chk($sformatf("%s rsp_timeout", tag), 32'(rsp_q.size() > 0), 32'd1);
    if (rsp_q.size() > 0 && acc_q.size() > 0)
      chk($sformatf("%s latency", tag), 32'(rsp_q[0] - acc_q[0]), 32'(LAT));
    chk($sformatf("%s rdata", tag), 32'(rsp_rdata), 32'(exp_rd));
    chk($sformatf("%s frames", tag), 32'(frame_q.size()), 32'd1);
    if (frame_q.size() > 0) chk($sformatf("%s mosi", tag), 32'(frame_q[0]), 32'(exp_frame));
    @(negedge clk); @(negedge clk);
    chk($sformatf("%s rsp_pulse", tag), 32'(rsp_q.size()), 32'd1);
    if (w) ref_mem[a] = d;
    $display("cmd %s: %s addr=0x%0h data=0x%0h rdata=0x%0h", tag, (w ? "WR" : "RD"), a, d, rsp_rdata);
  endtask

  initial begin
    int n;
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      s_mem[i]   = r[7:0];
      ref_mem[i] = r[7:0];
    end
    s_mem[5] = 8'h3C; ref_mem[5] = 8'h3C;
    s_mem[2] = 8'hC3; ref_mem[2] = 8'hC3;

    // ---- reset values ----
    #2 rst_n = 1'b0;
    #1;
    chk("rst cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst sclk", 32'(spi_clk), 32'd0);
    chk("rst mosi", 32'(spi_mosi), 32'd0);
    chk("rst ready", 32'(cmd_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rdata", 32'(rsp_rdata), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- directed frames ----
    run_cmd(1'b1, 4'h3, 8'hA5, "wr3");
    run_cmd(1'b0, 4'h5, 8'h77, "rd5");
    run_cmd(1'b0, 4'h2, 8'h00, "rd2");
    run_cmd(1'b0, 4'h3, 8'h00, "rd3_loop");

    // ---- back-to-back with cmd_valid held; also the busy hold-off ----
    acc_q.delete(); rsp_q.delete(); frame_q.delete();
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 8'h11; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_wdata = 8'h00;
    repeat (2 * D * 8) @(negedge clk);
    chk("b2b mid ready", 32'(cmd_ready), 32'd0);
    chk("b2b mid busy", 32'(busy), 32'd1);
    chk("b2b mid accepts", 32'(acc_q.size()), 32'd1);
    n = 0;
    while (acc_q.size() < 2 && n < 4 * LAT) begin @(negedge clk); n++; end
    cmd_valid = 1'b0;
    chk("b2b second accept", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() >= 2) chk("b2b accept gap", 32'(acc_q[1] - acc_q[0]), 32'(A2A));
    if (rsp_q.size() >= 1) chk("b2b rsp before accept", 32'(rsp_q[0] - acc_q[0]), 32'(LAT));
    n = 0;
    while (rsp_q.size() < 2 && n < 4 * LAT) begin @(negedge clk); n++; end
    chk("b2b rsp count", 32'(rsp_q.size()), 32'd2);
    chk("b2b rdata", 32'(rsp_rdata), 32'h11);
    chk("b2b frames", 32'(frame_q.size()), 32'd2);
    if (frame_q.size() >= 2) begin
      chk("b2b frame0", 32'(frame_q[0]), 32'h8111);
      chk("b2b frame1", 32'(frame_q[1]), 32'h0100);
    end
    ref_mem[1] = 8'h11;
    $display("cmd b2b: WR addr=0x1 data=0x11 then RD addr=0x1 rdata=0x%0h", rsp_rdata);

    // ---- reset mid-frame (bit 9 being shifted) ----
    run_cmd(1'b0, 4'h5, 8'h00, "rd5_pre_rst");
    acc_q.delete(); rsp_q.delete(); frame_q.delete();
    @(negedge clk);
    cmd_write = 1'b0; cmd_addr = 4'h2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (s_cnt < 7 && n < 4 * LAT) @(negedge clk) n++;
    chk("midrst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst cs_n", 32'(spi_cs_n), 32'd1);
    chk("midrst sclk", 32'(spi_clk), 32'd0);
    chk("midrst mosi", 32'(spi_mosi), 32'd0);
    chk("midrst busy_low", 32'(busy), 32'd0);
    chk("midrst rdata", 32'(rsp_rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 20) @(negedge clk);
    chk("midrst no rsp", 32'(rsp_q.size()), 32'd0);
    chk("midrst no frame", 32'(frame_q.size()), 32'd0);
    $display("cmd midrst: RD addr=0x2 abandoned by reset");
    run_cmd(1'b0, 4'h2, 8'h00, "rd2_post_rst");

    // ---- randomized commands against the reference register file ----
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      run_cmd(r[0], r[7:4], r[15:8], $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
